// File: rtl/mac_learning_lut_if.sv
// rtl/mac_learning_lut_if.sv - packet word bus between arbiter, lookup stage and output queues
interface mac_learning_lut_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic [CTRL_WIDTH-1:0] in_ctrl;
    logic                  in_wr;
    logic                  in_rdy;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic                  out_wr;
    logic                  out_rdy;

    modport master (
        output in_data, in_ctrl, in_wr, out_rdy,
        input  in_rdy, out_data, out_ctrl, out_wr
    );

    modport slave (
        input  in_data, in_ctrl, in_wr, out_rdy,
        output in_rdy, out_data, out_ctrl, out_wr
    );
endinterface

// File: rtl/mac_learning_lut.sv
// rtl/mac_learning_lut.sv - learning switch output-port lookup with a small fully-associative MAC table
module mac_learning_lut #(
    parameter int DATA_WIDTH        = 64,
    parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int NUM_ENTRIES       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mac_learning_lut_if.slave    bus,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);
    localparam int PW = $clog2(NUM_OUTPUT_QUEUES);
    localparam int EW = $clog2(NUM_ENTRIES);
    localparam logic [NUM_OUTPUT_QUEUES-1:0] ONE_HOT0 = 1;

    typedef enum logic [1:0] {CAPTURE, LOOKUP, DRAIN, STREAM} state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] hdr_buf  [3];
    logic [CTRL_WIDTH-1:0] ctrl_buf [3];
    logic [1:0]            cnt;
    logic [1:0]            last_idx;
    logic [1:0]            rd_ptr;
    logic                  short_pkt;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CTRL_WIDTH-1:0] out_ctrl_q;

    logic [NUM_ENTRIES-1:0] tbl_valid;
    logic [47:0]            tbl_mac  [NUM_ENTRIES];
    logic [PW-1:0]          tbl_port [NUM_ENTRIES];
    logic [EW-1:0]          wr_ptr;

    logic                  in_eop;
    logic [15:0]           src_port;
    logic [PW-1:0]         p;
    logic [47:0]           dst_mac;
    logic [47:0]           src_mac;
    logic [NUM_OUTPUT_QUEUES-1:0] flood;
    logic [NUM_OUTPUT_QUEUES-1:0] self_bit;
    logic [NUM_OUTPUT_QUEUES-1:0] new_dst;
    logic [DATA_WIDTH-1:0] new_hdr;
    logic                  dst_hit, src_hit;
    logic [EW-1:0]         dst_idx, src_idx;
    logic                  count_hit, count_miss, learn;
    logic                  in_rdy, out_wr;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic                  unused_bits;

    assign in_eop   = (bus.in_ctrl != '0);
    assign src_port = hdr_buf[0][31:16];
    assign p        = src_port[PW-1:0];
    assign dst_mac  = hdr_buf[1][63:16];
    assign src_mac  = {hdr_buf[1][15:0], hdr_buf[2][63:32]};
    assign self_bit = ONE_HOT0 << p;
    assign new_hdr  = {16'(new_dst), hdr_buf[0][DATA_WIDTH-17:0]};
    assign unused_bits = ^{src_port[15:PW], hdr_buf[2][31:0]};

    always_comb begin
        flood = '0;
        for (int i = 0; i < NUM_OUTPUT_QUEUES; i += 2)
            flood[i] = 1'b1;
    end

    // Descending scan so the lowest matching index wins; compares see the pre-update table.
    always_comb begin
        dst_hit = 1'b0;
        dst_idx = '0;
        src_hit = 1'b0;
        src_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (tbl_valid[i] && tbl_mac[i] == dst_mac) begin
                dst_hit = 1'b1;
                dst_idx = EW'(i);
            end
            if (tbl_valid[i] && tbl_mac[i] == src_mac) begin
                src_hit = 1'b1;
                src_idx = EW'(i);
            end
        end
    end

    always_comb begin
        new_dst    = '0;
        count_hit  = 1'b0;
        count_miss = 1'b0;
        learn      = 1'b0;
        if (p[0]) begin
            new_dst = ONE_HOT0 << (p - 1'b1);
        end else begin
            learn = !short_pkt && !src_mac[40];
            if (short_pkt || dst_mac[40]) begin
                new_dst = flood & ~self_bit;
            end else if (dst_hit) begin
                count_hit = 1'b1;
                new_dst   = (tbl_port[dst_idx] == p) ? '0 : (ONE_HOT0 << tbl_port[dst_idx]);
            end else begin
                count_miss = 1'b1;
                new_dst    = flood & ~self_bit;
            end
        end
    end

    always_comb begin
        state_next = state;
        in_rdy     = 1'b0;
        out_wr     = 1'b0;
        out_data   = out_data_q;
        out_ctrl   = out_ctrl_q;
        case (state)
            CAPTURE: begin
                in_rdy = 1'b1;
                if (bus.in_wr && cnt != 2'd0 && (cnt == 2'd2 || in_eop))
                    state_next = LOOKUP;
            end
            LOOKUP: state_next = DRAIN;
            DRAIN: begin
                out_wr = bus.out_rdy;
                if (bus.out_rdy && rd_ptr == last_idx)
                    state_next = short_pkt ? CAPTURE : STREAM;
            end
            STREAM: begin
                out_data = bus.in_data;
                out_ctrl = bus.in_ctrl;
                out_wr   = bus.in_wr;
                in_rdy   = bus.out_rdy;
                if (bus.in_wr && in_eop)
                    state_next = CAPTURE;
            end
            default: state_next = CAPTURE;
        endcase
    end

    assign bus.in_rdy   = in_rdy;
    assign bus.out_wr   = out_wr;
    assign bus.out_data = out_data;
    assign bus.out_ctrl = out_ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CAPTURE;
            cnt        <= 2'd0;
            last_idx   <= 2'd0;
            rd_ptr     <= 2'd0;
            short_pkt  <= 1'b0;
            out_data_q <= '0;
            out_ctrl_q <= '0;
            tbl_valid  <= '0;
            wr_ptr     <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_next;
            case (state)
                CAPTURE: begin
                    if (bus.in_wr) begin
                        hdr_buf[cnt]  <= bus.in_data;
                        ctrl_buf[cnt] <= bus.in_ctrl;
                        if (cnt != 2'd0 && (cnt == 2'd2 || in_eop)) begin
                            cnt       <= 2'd0;
                            last_idx  <= cnt;
                            short_pkt <= in_eop;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                LOOKUP: begin
                    out_data_q <= new_hdr;
                    out_ctrl_q <= ctrl_buf[0];
                    rd_ptr     <= 2'd0;
                    if (count_hit && hit_count != '1)
                        hit_count <= hit_count + 32'd1;
                    if (count_miss && miss_count != '1)
                        miss_count <= miss_count + 32'd1;
                    // Known sources just move port; new ones take the oldest slot.
                    if (learn) begin
                        if (src_hit) begin
                            tbl_port[src_idx] <= p;
                        end else begin
                            tbl_valid[wr_ptr] <= 1'b1;
                            tbl_mac[wr_ptr]   <= src_mac;
                            tbl_port[wr_ptr]  <= p;
                            wr_ptr            <= wr_ptr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.out_rdy && rd_ptr != last_idx) begin
                        rd_ptr     <= rd_ptr + 2'd1;
                        out_data_q <= hdr_buf[rd_ptr + 2'd1];
                        out_ctrl_q <= ctrl_buf[rd_ptr + 2'd1];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_learning_lut.sv
// tb/tb_mac_learning_lut.sv - scoreboard bench for mac_learning_lut
module tb_mac_learning_lut;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] hit_count, miss_count;

    mac_learning_lut_if #(.DATA_WIDTH(64)) bus_if ();

    mac_learning_lut dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  ctrl;
        bit          buffered;
        bit          is_hdr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   out_cnt  = 0;
    int   hdr_cyc  = 0;
    int   w2_cyc   = 0;
    bit   toggle   = 0;

    logic [47:0] m_mac   [16];
    int          m_port  [16];
    bit          m_valid [16];
    int          m_wp;
    int          m_hit, m_miss;

    localparam logic [47:0] MAC_A = 48'h00000000000A;
    localparam logic [47:0] MAC_B = 48'h00000000000B;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus_if.out_wr) begin
            check_eq("out_wr_needs_rdy", 64'(bus_if.out_rdy), 64'd1);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_word", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("out_data", bus_if.out_data, e.data);
                check_eq("out_ctrl", 64'(bus_if.out_ctrl), 64'(e.ctrl));
                if (e.buffered)
                    check_eq("in_rdy_in_drain", 64'(bus_if.in_rdy), 64'd0);
                if (e.is_hdr)
                    hdr_cyc = cyc;
                out_cnt++;
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_wp   = 0;
        m_hit  = 0;
        m_miss = 0;
    endtask

    task automatic model_packet(input int p, input logic [47:0] dst, input logic [47:0] src,
                                input bit short_pkt, output logic [15:0] dst_field);
        logic [15:0] flood;
        int          hit_e, src_e;
        flood = 16'h0055;
        if (p % 2 == 1) begin
            dst_field = 16'(1) << (p - 1);
            return;
        end
        if (short_pkt || dst[40]) begin
            dst_field = flood & ~(16'(1) << p);
        end else begin
            hit_e = -1;
            for (int i = 0; i < 16; i++)
                if (hit_e < 0 && m_valid[i] && m_mac[i] == dst) hit_e = i;
            if (hit_e >= 0) begin
                m_hit++;
                dst_field = (m_port[hit_e] == p) ? 16'h0 : (16'(1) << m_port[hit_e]);
            end else begin
                m_miss++;
                dst_field = flood & ~(16'(1) << p);
            end
        end
        if (!short_pkt && !src[40]) begin
            src_e = -1;
            for (int i = 0; i < 16; i++)
                if (src_e < 0 && m_valid[i] && m_mac[i] == src) src_e = i;
            if (src_e >= 0) begin
                m_port[src_e] = p;
            end else begin
                m_valid[m_wp] = 1;
                m_mac[m_wp]   = src;
                m_port[m_wp]  = p;
                m_wp          = (m_wp + 1) % 16;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        bus_if.in_wr = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        model_reset();
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_hit_count"}, 64'(hit_count), 64'(m_hit));
        check_eq({tag, "_miss_count"}, 64'(miss_count), 64'(m_miss));
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk); #1;
            bus_if.out_rdy = toggle ? ~bus_if.out_rdy : 1'b1;
            if (++guard > 300) begin
                check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
                return;
            end
        end
        @(posedge clk); #1;
        bus_if.out_rdy = 1'b1;
    endtask

    // ndata data words follow the header; abort_after > 0 resets the block before that word index.
    task automatic send_pkt(input int p, input logic [47:0] dst, input logic [47:0] src,
                            input int ndata, input int abort_after);
        logic [63:0] w [$];
        logic [7:0]  c [$];
        logic [15:0] dst_field;
        exp_t        e;
        int          guard;
        bit          sent;
        w.push_back({16'h0000, 16'(ndata), 16'(p), 16'(ndata * 8)});
        c.push_back(8'hFF);
        for (int i = 1; i <= ndata; i++) begin
            if (i == 1)      w.push_back({dst, src[47:32]});
            else if (i == 2) w.push_back({src[31:0], 32'($urandom())});
            else             w.push_back({32'($urandom()), 32'($urandom())});
            c.push_back(i == ndata ? 8'h80 : 8'h00);
        end
        model_packet(p, dst, src, ndata <= 2, dst_field);
        for (int i = 0; i <= ndata; i++) begin
            e.data     = (i == 0) ? {dst_field, w[0][47:0]} : w[i];
            e.ctrl     = c[i];
            e.buffered = (i < 3);
            e.is_hdr   = (i == 0);
            exp_q.push_back(e);
        end
        for (int i = 0; i <= ndata; i++) begin
            if (abort_after > 0 && i == abort_after) begin
                do_reset();
                return;
            end
            sent  = 0;
            guard = 0;
            while (!sent) begin
                @(posedge clk); #1;
                bus_if.in_wr   = 1'b0;
                bus_if.out_rdy = toggle ? ~bus_if.out_rdy : 1'b1;
                #1;
                if (bus_if.in_rdy) begin
                    bus_if.in_data = w[i];
                    bus_if.in_ctrl = c[i];
                    bus_if.in_wr   = 1'b1;
                    sent = 1;
                    if (i == 2) w2_cyc = cyc;
                end else if (++guard > 200) begin
                    check_eq("in_rdy_timeout", 64'(bus_if.in_rdy), 64'd1);
                    bus_if.in_wr = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk); #1;
        bus_if.in_wr = 1'b0;
    endtask

    initial begin
        int cnt0;
        reset          = 1'b1;
        bus_if.in_wr   = 1'b0;
        bus_if.in_data = '0;
        bus_if.in_ctrl = '0;
        bus_if.out_rdy = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_out_wr", 64'(bus_if.out_wr), 64'd0);
        check_eq("rst_out_data", bus_if.out_data, 64'd0);
        check_eq("rst_out_ctrl", 64'(bus_if.out_ctrl), 64'd0);
        check_eq("rst_in_rdy", 64'(bus_if.in_rdy), 64'd1);
        check_counters("rst");

        // learn A on port 0, miss to B
        send_pkt(0, MAC_B, MAC_A, 4, 0);
        wait_drain();
        check_eq("hdr_latency", 64'(hdr_cyc - w2_cyc), 64'd2);
        check_counters("t1");

        // hit back to A, then hit to freshly learned B, then self-port hit
        send_pkt(2, MAC_A, MAC_B, 3, 0);
        send_pkt(4, MAC_B, 48'h00000000000C, 3, 0);
        send_pkt(2, MAC_B, 48'h00000000000F, 3, 0);
        wait_drain();
        check_counters("t2");

        // broadcast and CPU-port packets
        send_pkt(4, BCAST, 48'h00000000000D, 3, 0);
        send_pkt(3, MAC_A, 48'h00000000000E, 3, 0);
        wait_drain();
        check_counters("t3");

        // FIFO replacement: 17 sources evict the first
        do_reset();
        for (int k = 0; k < 17; k++)
            send_pkt(6, BCAST, 48'h020000000100 + 48'(k), 3, 0);
        send_pkt(0, 48'h020000000100, MAC_A, 3, 0);
        send_pkt(0, 48'h020000000110, MAC_A, 3, 0);
        wait_drain();
        check_counters("t4");

        // backpressure on alternate cycles over a 10-word packet
        toggle = 1;
        cnt0 = out_cnt;
        send_pkt(0, 48'h020000000110, MAC_B, 9, 0);
        wait_drain();
        toggle = 0;
        check_eq("words_out_10", 64'(out_cnt - cnt0), 64'd10);
        check_counters("t5");

        // short packet floods without learning its source
        send_pkt(2, MAC_B, 48'h000000001234, 2, 0);
        send_pkt(0, 48'h000000001234, MAC_A, 3, 0);
        wait_drain();
        check_counters("t6a");

        // reset in the middle of streaming
        send_pkt(0, MAC_B, MAC_A, 8, 5);
        @(negedge clk);
        check_eq("abort_out_wr", 64'(bus_if.out_wr), 64'd0);
        check_eq("abort_in_rdy", 64'(bus_if.in_rdy), 64'd1);
        check_counters("abort");
        send_pkt(0, MAC_B, MAC_A, 3, 0);
        wait_drain();
        check_counters("t6b");

        repeat (5) @(posedge clk);
        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
